// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling, start-bit validation and framing-error detection
//
// Ports:
//   i_clock        system clock, all logic on the rising edge
//   i_reset        asynchronous active-high reset
//   i_tick         one-clock pulse at 16x the baud rate
//   i_rx_data      serial line, idle high, asynchronous to i_clock
//   o_data_byte    last correctly received byte, zero-extended when DATA_BITS < 8
//   o_rx_done      one-clock pulse when a frame with a good stop bit completes
//   o_frame_error  one-clock pulse when the stop bit samples low

module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICK   = 16
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_rx_data,
    output logic [7:0] o_data_byte,
    output logic       o_rx_done,
    output logic       o_frame_error
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_t;

    localparam logic [4:0] START_MID = 5'd7;
    localparam logic [4:0] BIT_LAST  = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    state_t                 state_q;
    logic [4:0]             tick_cnt_q;
    logic [2:0]             bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   sync1_q;
    logic                   rx_s;

    // Two-flop synchroniser; both stages reset to the idle (high) level so
    // reset release never looks like a start bit.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= i_rx_data;
            rx_s    <= sync1_q;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            o_data_byte   <= '0;
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            // Pulses are cleared every clock unless set below.
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;

            case (state_q)
                // Start detection is not gated by i_tick, so a start bit that
                // follows the stop sample directly is caught immediately.
                IDLE: begin
                    if (!rx_s) begin
                        state_q    <= START;
                        tick_cnt_q <= '0;
                    end
                end

                START: begin
                    if (i_tick) begin
                        if (tick_cnt_q == START_MID) begin
                            if (!rx_s) begin
                                state_q    <= DATA;
                                tick_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                            end else begin
                                // Line went back high before mid-bit: glitch.
                                state_q <= IDLE;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 5'd1;
                        end
                    end
                end

                // Counting from the start-bit centre, every 16th tick lands
                // on the centre of the next data bit.
                DATA: begin
                    if (i_tick) begin
                        if (tick_cnt_q == BIT_LAST) begin
                            tick_cnt_q <= '0;
                            if (DATA_BITS > 1) begin
                                shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                            end else begin
                                shift_q <= rx_s;
                            end
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= STOP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 5'd1;
                        end
                    end
                end

                STOP: begin
                    if (i_tick) begin
                        if (tick_cnt_q == STOP_LAST) begin
                            if (rx_s) begin
                                o_data_byte <= 8'(shift_q);
                                o_rx_done   <= 1'b1;
                            end else begin
                                o_frame_error <= 1'b1;
                            end
                            state_q    <= IDLE;
                            tick_cnt_q <= '0;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 5'd1;
                        end
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    tick_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: directed vector table, corner sequences, randomized frames

module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       rxd;
    logic [7:0] dout;
    logic       done;
    logic       ferr;

    always #5 clk = ~clk;

    uart_rx #(.DATA_BITS(8), .SB_TICK(16)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_tick       (tick),
        .i_rx_data    (rxd),
        .o_data_byte  (dout),
        .o_rx_done    (done),
        .o_frame_error(ferr)
    );

    int tests = 0;
    int fails = 0;

    // Tick generator: one-clock pulse every tick_per clocks.
    int tick_per = 16;
    int tdiv     = 0;
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tdiv = (tdiv + 1 >= tick_per) ? 0 : tdiv + 1;
            tick = (tdiv == 0);
        end
    end

    // Pulse logger: records each rising pulse and counts pulses longer than one clock.
    logic [7:0] ev_byte [512];
    bit         ev_done [512];
    bit         ev_err  [512];
    int         n_obs    = 0;
    int         wide_cnt = 0;
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if ((done || ferr) && prev) wide_cnt++;
                if ((done || ferr) && !prev && n_obs < 512) begin
                    ev_done[n_obs] = done;
                    ev_err[n_obs]  = ferr;
                    ev_byte[n_obs] = dout;
                    n_obs++;
                end
                prev = done || ferr;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish, got %0d tests required completion", tests);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    int exp_idx = 0;
    task automatic expect_event(input string name, input bit edone, input bit eerr, input logic [7:0] eb);
        tests++;
        if (exp_idx >= n_obs) begin
            fails++;
            $display("FAIL %s: no pulse seen, expected done=%0d err=%0d byte=0x%02h", name, edone, eerr, eb);
        end else begin
            if (ev_done[exp_idx] !== edone || ev_err[exp_idx] !== eerr || ev_byte[exp_idx] !== eb) begin
                fails++;
                $display("FAIL %s: got done=%0d err=%0d byte=0x%02h expected done=%0d err=%0d byte=0x%02h",
                         name, ev_done[exp_idx], ev_err[exp_idx], ev_byte[exp_idx], edone, eerr, eb);
            end
            exp_idx++;
        end
    endtask

    // Wait until n ticks have been consumed, then step just past the edge.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic tx_bit(input logic b);
        rxd = b;
        wait_ticks(16);
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        if (n > 0) wait_ticks(16 * n);
    endtask

    // A bad stop bit is low through its centre, then returns high before
    // the bit ends so that the receiver sees no follow-on start.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        tx_bit(1'b0);
        for (int i = 0; i < 8; i++) tx_bit(d[i]);
        if (stop_ok) begin
            tx_bit(1'b1);
        end else begin
            rxd = 1'b0;
            wait_ticks(12);
            rxd = 1'b1;
            wait_ticks(4);
        end
    endtask

    task automatic send_glitch(input int k);
        rxd = 1'b0;
        wait_ticks(k);
        rxd = 1'b1;
        wait_ticks(16 - k);
    endtask

    typedef struct {
        int         glitch_ticks;
        logic [7:0] data;
        bit         stop_ok;
        int         gap_bits;
        bit         exp_done;
        bit         exp_err;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [7:0] last_good;
        logic [7:0] d;
        bit         ok;

        vecs[0] = '{0, 8'h55, 1'b1, 1, 1'b1, 1'b0, 8'h55};
        vecs[1] = '{0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{0, 8'hFF, 1'b1, 1, 1'b1, 1'b0, 8'hFF};
        vecs[3] = '{4, 8'h3C, 1'b1, 1, 1'b1, 1'b0, 8'h3C};
        vecs[4] = '{0, 8'hA5, 1'b0, 1, 1'b0, 1'b1, 8'h3C};

        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", dout, 8'h00);
        check("reset_done", done, 1'b0);
        check("reset_ferr", ferr, 1'b0);
        rst = 1'b0;

        wait_ticks(100);
        check("idle_data", dout, 8'h00);
        check("idle_no_pulse", n_obs, 0);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].glitch_ticks > 0) begin
                send_glitch(vecs[i].glitch_ticks);
                check($sformatf("vec%0d_glitch_no_pulse", i), n_obs, exp_idx);
            end
            send_frame(vecs[i].data, vecs[i].stop_ok);
            idle_bits(vecs[i].gap_bits);
            expect_event($sformatf("vec%0d_pulse", i), vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_byte);
            check($sformatf("vec%0d_data_hold", i), dout, vecs[i].exp_byte);
        end
        check("table_no_extra", n_obs, exp_idx);

        // Reset after three data bits of 0x81 aborts the frame asynchronously.
        tx_bit(1'b0);
        tx_bit(1'b1);
        tx_bit(1'b0);
        tx_bit(1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_data", dout, 8'h00);
        check("midreset_done", done, 1'b0);
        check("midreset_ferr", ferr, 1'b0);
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_bits(1);
        check("midreset_no_pulse", n_obs, exp_idx);
        send_frame(8'h81, 1'b1);
        idle_bits(1);
        expect_event("after_reset_81", 1'b1, 1'b0, 8'h81);
        check("after_reset_data", dout, 8'h81);

        // Randomized frames at a faster tick rate against a frame-level model.
        tick_per  = 4;
        last_good = 8'h81;
        idle_bits(1);
        for (int i = 0; i < 30; i++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) send_glitch(int'($urandom_range(1, 5)));
            send_frame(d, ok);
            idle_bits(ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
            if (ok) begin
                last_good = d;
                expect_event($sformatf("rand%0d_done", i), 1'b1, 1'b0, d);
            end else begin
                expect_event($sformatf("rand%0d_ferr", i), 1'b0, 1'b1, last_good);
            end
            check($sformatf("rand%0d_data_hold", i), dout, last_good);
        end
        idle_bits(2);
        check("final_no_extra", n_obs, exp_idx);
        check("pulse_width", wide_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver stage that consumes the line driven by the UART transmitter and recovers 8N1 frames into parallel bytes. It shares the transmitter's 16x oversampling `i_tick` from the common baud generator. It synchronises the asynchronous line, detects and validates the start bit at mid-bit, and shifts data in LSB first. On a good stop bit it emits a one-clock done pulse with the byte; on a bad stop bit it emits a one-clock frame-error pulse.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first; legal range 5..8.
- `SB_TICK`, default 16: ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- `i_clock`  in  1  system clock; all logic on its rising edge.
- `i_reset`  in  1  reset; one clock, reset is asynchronous and active-high.
- `i_tick`  in  1  one-clock pulse at 16x baud rate.
- `i_rx_data`  in  1  serial line; idle high; asynchronous to `i_clock`.
- `o_data_byte`  out  8  last correctly received byte; unused MSBs are 0 when DATA_BITS<8.
- `o_rx_done`  out  1  one-clock pulse when a valid frame completes.
- `o_frame_error`  out  1  one-clock pulse when the stop bit samples low.

## Operation
- Synchroniser: two flops on `i_rx_data`, both reset to 1. All FSM logic uses the second-stage output `rx_s`.
- Counters:
  - `tick_cnt`: 5 bits; counts `i_tick` pulses within a bit.
  - `bit_cnt`: 3 bits; index of the current data bit.
  - `shift_reg`: DATA_BITS wide; shifts right, with new bits entering at the MSB.
- States are one-hot: IDLE, START, DATA, STOP.
- IDLE:
  - Evaluated every clock, independent of `i_tick`.
  - `rx_s`==0 -> START, with `tick_cnt`=0.
- START: advances only on clocks where `i_tick`=1.
  - Increment `tick_cnt` while it is <7.
  - At `tick_cnt`==7 (mid start bit), `rx_s`==0 -> DATA, with `tick_cnt`=0 and `bit_cnt`=0.
  - At `tick_cnt`==7, `rx_s`==1 -> IDLE (false start / glitch). No pulse.
- DATA: advances only on `i_tick`.
  - At `tick_cnt`==15, sample `rx_s` into `shift_reg` MSB (shift right) and set `tick_cnt`=0.
  - If `bit_cnt`==DATA_BITS-1 -> STOP; otherwise increment `bit_cnt`.
  - Otherwise increment `tick_cnt`.
- STOP: advances only on `i_tick`.
  - At `tick_cnt`==SB_TICK-1, sample `rx_s`:
    - `rx_s`==1: `o_data_byte` <= `shift_reg`, `o_rx_done` <= 1.
    - `rx_s`==0: `o_frame_error` <= 1; `o_data_byte` unchanged.
  - In both cases -> IDLE.
- Pulses: `o_rx_done` and `o_frame_error` are registered and cleared on every clock they are not set, so each pulse lasts exactly one clock. They are never both high.
- Illegal or unknown state -> IDLE, with counters cleared.
- Back-to-back frames: IDLE is reachable on the same clock as the stop sample. A start bit immediately following the stop bit is detected without requiring an extra idle bit.

## Timing
- Reset values:
  - `o_data_byte`=0, `o_rx_done`=0, `o_frame_error`=0.
  - State IDLE; all counters 0; `shift_reg`=0; synchroniser flops=1.
- Reset asserted mid-frame aborts immediately, asynchronously. The partial frame is discarded with no pulse.
- Start detection latency: 2 clocks (synchroniser) + 1 clock from a falling edge on `i_rx_data` until the state is START.
- Data bit n is sampled on the 16th tick after the start-bit mid-point, offset by 16·n ticks, i.e. at bit centre.
- The done or error pulse appears the clock after the `i_tick` on which the STOP sample is taken. `o_data_byte` is valid in that same cycle and holds until the next good frame.
- `i_tick` high while in IDLE has no effect. Ticks are not counted until the state is START.

## Test plan
- **Reset and idle.** Assert `i_reset`, release, then hold line high for 100 ticks -> `o_data_byte`=0x00, and `o_rx_done`/`o_frame_error` never assert.
- **Single frame.** Tick every 16 clocks; send 0x55 as 8N1 -> exactly one `o_rx_done` pulse, one clock wide, with `o_data_byte`=0x55 and `o_frame_error`=0.
- **Back-to-back frames.** Send 0x00 then 0xFF with no gap between frames -> two `o_rx_done` pulses, carrying 0x00 then 0xFF.
- **Glitch rejection.** Drive line low for 4 ticks, then high -> FSM returns to IDLE with no pulse. Then send 0x3C -> `o_data_byte`=0x3C.
- **Framing error.** Send 0xA5 with the stop bit driven low -> one `o_frame_error` pulse, `o_rx_done`=0, and `o_data_byte` stays 0x3C.
- **Reset mid-frame.** Assert `i_reset` after 3 data bits -> all outputs return to 0 immediately. The next frame, 0x81, is received correctly.
